// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: single-outstanding req/ack with byte enables.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/halfword/word loads and stores over a single-outstanding
// req/ack port, with a one-cycle write-back strobe. ADDR_W must lie in 3..32.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [5:0]               opcode,
    input  logic [31:0]              alu_rslt,
    input  logic [31:0]              st_data,
    load_store_unit_if.master        mem,
    output logic                     busy,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    output logic                     misalign
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic [1:0]        state_q;
    logic [5:0]        op_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       out_data_q;
    logic              misalign_q;

    logic [1:0]  off;
    logic        is_load;
    logic        is_store;
    logic        bad_align;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;

    assign off = alu_rslt[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        bad_align = 1'b0;
        be_in     = 4'b1111;
        wdata_in  = st_data;
        case (opcode)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load   = 1'b1;
                bad_align = off[0];
            end
            OP_LW: begin
                is_load   = 1'b1;
                bad_align = |off;
            end
            OP_SB: begin
                is_store = 1'b1;
                be_in    = 4'b0001 << off;
                wdata_in = {4{st_data[7:0]}};
            end
            OP_SH: begin
                is_store  = 1'b1;
                bad_align = off[0];
                be_in     = 4'b0011 << off;
                wdata_in  = {2{st_data[15:0]}};
            end
            OP_SW: begin
                is_store  = 1'b1;
                bad_align = |off;
            end
            default: ;
        endcase
    end

    // Lane extraction uses only the latched offset/opcode; rdata is sampled in the ack cycle.
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    assign rd_shift = mem.mem_rdata >> {off_q, 3'b000};
    assign rd_half  = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        load_val = mem.mem_rdata;
        case (op_q)
            OP_LB:   load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_val = {24'h0, rd_shift[7:0]};
            OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_val = {16'h0, rd_half};
            default: load_val = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 6'h0;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            out_data_q <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!(is_load || is_store)) begin
                            out_data_q <= alu_rslt;
                            misalign_q <= 1'b0;
                            state_q    <= RESP;
                        end else if (bad_align) begin
                            out_data_q <= 32'h0;
                            misalign_q <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            op_q    <= opcode;
                            off_q   <= off;
                            we_q    <= is_store;
                            addr_q  <= {alu_rslt[ADDR_W-1:2], 2'b00};
                            be_q    <= be_in;
                            wdata_q <= wdata_in;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem.mem_ack) begin
                        out_data_q <= we_q ? 32'h0 : load_val;
                        misalign_q <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
    assign busy          = (state_q != IDLE);
    assign out_valid     = (state_q == RESP);
    assign out_data      = out_data_q;
    assign misalign      = misalign_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a behavioural model sets per-cycle expectations
// that one negedge process compares, plus literal checks on captured results.
module tb_load_store_unit;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  opcode;
    logic [31:0] alu_rslt;
    logic [31:0] st_data;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_data;
    logic        misalign;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) mem_bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .alu_rslt  (alu_rslt),
        .st_data   (st_data),
        .mem       (mem_bus),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .misalign  (misalign)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        chk_en = 1'b0;
    logic        e_busy, e_valid, e_req, e_we, e_mis;
    logic [31:0] e_data, e_addr, e_wdata;
    logic [3:0]  e_be;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: what the stage must produce, stated in terms of access sizes and byte lanes.
    function automatic bit m_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic bit m_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic int m_size(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input int a);
        int mask;
        if (!m_store(op)) return 4'hF;
        mask = ((1 << m_size(op)) - 1) << a;
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] st);
        if (op == OP_SB) return (st & 32'hFF) * 32'h0101_0101;
        if (op == OP_SH) return (st & 32'hFFFF) * 32'h0001_0001;
        return st;
    endfunction

    function automatic logic [31:0] m_load_val(input logic [5:0] op, input int a,
                                               input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (8 * a)) & 32'hFFFF;
        case (op)
            OP_LB:   return (b ^ 32'h80) - 32'h80;
            OP_LBU:  return b;
            OP_LH:   return (h ^ 32'h8000) - 32'h8000;
            OP_LHU:  return h;
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check32("busy", {31'h0, busy}, {31'h0, e_busy});
            check32("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
            check32("mem_req", {31'h0, mem_bus.mem_req}, {31'h0, e_req});
            if (e_valid) begin
                check32("out_data", out_data, e_data);
                check32("misalign", {31'h0, misalign}, {31'h0, e_mis});
            end
            if (e_req) begin
                check32("mem_we", {31'h0, mem_bus.mem_we}, {31'h0, e_we});
                check32("mem_addr", mem_bus.mem_addr, e_addr);
                check32("mem_be", {28'h0, mem_bus.mem_be}, {28'h0, e_be});
                check32("mem_wdata", mem_bus.mem_wdata, e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_busy  = 1'b0;
        e_valid = 1'b0;
        e_req   = 1'b0;
    endtask

    task automatic check_reset_vals();
        check32("rst_mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
        check32("rst_mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
        check32("rst_busy", {31'h0, busy}, 32'h0);
        check32("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check32("rst_misalign", {31'h0, misalign}, 32'h0);
        check32("rst_out_data", out_data, 32'h0);
        check32("rst_mem_addr", mem_bus.mem_addr, 32'h0);
        check32("rst_mem_be", {28'h0, mem_bus.mem_be}, 32'h0);
        check32("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
    endtask

    // Presents one instruction in the current (idle) cycle; returns in the idle cycle after RESP.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] st,
                          input logic [31:0] rd, input int k, input bit noise,
                          output logic [31:0] got, output logic got_mis);
        bit ls;
        bit mem_op;
        int off;
        ls     = m_load(op) || m_store(op);
        off    = int'(a[1:0]);
        mem_op = ls && (off % m_size(op)) == 0;
        opcode   = op;
        alu_rslt = a;
        st_data  = st;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (!mem_op) begin
            e_busy  = 1'b1;
            e_valid = 1'b1;
            e_req   = 1'b0;
            e_data  = ls ? 32'h0 : a;
            e_mis   = ls;
        end else begin
            e_addr  = a & 32'hFFFF_FFFC;
            e_be    = m_be(op, off);
            e_wdata = m_wdata(op, st);
            e_we    = m_store(op);
            for (int i = 1; i <= k; i++) begin
                e_busy  = 1'b1;
                e_req   = 1'b1;
                e_valid = 1'b0;
                mem_bus.mem_ack   = (i == k);
                mem_bus.mem_rdata = (i == k) ? rd : ~rd;
                if (noise) begin
                    in_valid = 1'b1;
                    opcode   = OP_SW;
                    alu_rslt = 32'h0000_0F00;
                    st_data  = 32'h1111_1111;
                end
                step();
            end
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = 32'h0;
            e_req   = 1'b0;
            e_busy  = 1'b1;
            e_valid = 1'b1;
            e_data  = m_store(op) ? 32'h0 : m_load_val(op, off, rd);
            e_mis   = 1'b0;
        end
        in_valid = noise;
        @(negedge clk);
        got     = out_data;
        got_mis = misalign;
        step();
        in_valid = 1'b0;
        set_idle();
    endtask

    logic [31:0] got;
    logic        gm;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = 6'h0;
        alu_rslt = 32'h0;
        st_data  = 32'h0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        set_idle();
        step();
        step();
        rst = 1'b0;
        check_reset_vals();
        chk_en = 1'b1;
        step();

        run_op(6'h00, 32'h1234_5678, 32'h0, 32'h0, 1, 1'b0, got, gm);
        check32("lit_pass", got, 32'h1234_5678);
        run_op(OP_LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 1'b0, got, gm);
        check32("lit_lb", got, 32'hFFFF_FF80);
        run_op(OP_LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 1'b0, got, gm);
        check32("lit_lbu", got, 32'h0000_0080);
        run_op(OP_SH, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 4, 1'b1, got, gm);
        check32("lit_sh", got, 32'h0);
        run_op(OP_LW, 32'h0000_0301, 32'h0, 32'h0, 1, 1'b0, got, gm);
        check32("lit_lw_mis_data", got, 32'h0);
        check32("lit_lw_mis_flag", {31'h0, gm}, 32'h1);

        // Reset while a store waits for its ack; a late ack must be ignored.
        opcode   = OP_SW;
        alu_rslt = 32'h0000_0500;
        st_data  = 32'hCAFE_F00D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        e_busy  = 1'b1;
        e_req   = 1'b1;
        e_valid = 1'b0;
        e_we    = 1'b1;
        e_addr  = 32'h0000_0500;
        e_be    = 4'hF;
        e_wdata = 32'hCAFE_F00D;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_idle();
        check_reset_vals();
        mem_bus.mem_ack = 1'b1;
        step();
        step();
        mem_bus.mem_ack = 1'b0;
        step();

        run_op(OP_LW, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, got, gm);
        check32("lit_lw", got, 32'hDEAD_BEEF);
        run_op(OP_LHU, 32'h0000_0402, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, got, gm);
        check32("lit_lhu", got, 32'h0000_DEAD);

        run_op(OP_LH, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 1, 1'b0, got, gm);
        check32("lit_lh", got, 32'hFFFF_8001);
        run_op(OP_LH, 32'h0000_0104, 32'h0, 32'h8001_7FFF, 3, 1'b1, got, gm);
        check32("lit_lh_pos", got, 32'h0000_7FFF);
        run_op(OP_LB, 32'h0000_0110, 32'h0, 32'h0000_0042, 1, 1'b0, got, gm);
        check32("lit_lb_pos", got, 32'h0000_0042);
        run_op(OP_SB, 32'h0000_0007, 32'h0000_005A, 32'h0, 2, 1'b0, got, gm);
        run_op(OP_SB, 32'h0000_0005, 32'h0000_00C3, 32'h0, 1, 1'b0, got, gm);
        run_op(OP_SH, 32'h0000_0200, 32'h1234_5678, 32'h0, 1, 1'b0, got, gm);
        run_op(OP_SW, 32'h0000_0ABC, 32'h0BAD_F00D, 32'h0, 2, 1'b0, got, gm);
        run_op(OP_LH, 32'h0000_0101, 32'h0, 32'h0, 1, 1'b0, got, gm);
        check32("lit_lh_mis", {31'h0, gm}, 32'h1);
        run_op(OP_SH, 32'h0000_0203, 32'h0, 32'h0, 1, 1'b0, got, gm);
        run_op(OP_SW, 32'h0000_0302, 32'h0, 32'h0, 1, 1'b0, got, gm);
        run_op(6'h0F, 32'hFFFF_0001, 32'h0, 32'h0, 1, 1'b0, got, gm);
        check32("lit_nonmem", got, 32'hFFFF_0001);

        // Reset wins over a simultaneous in_valid.
        opcode   = OP_LW;
        alu_rslt = 32'h0000_0600;
        in_valid = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        set_idle();
        step();
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
